// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter: shares Grid_Mem port A between the piece-move controller
// (req 0) and the row-clear engine (req 1). Registered grants, combinational
// access mux, and a read-tag pipe that routes mem_q back to the issuer.
module grid_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Counter only needs to reach MAX_HOLD; it saturates there.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                last_owner_q, last_owner_d;
  logic [READ_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [READ_LAT-1:0] rd_id_q, rd_id_d;

  logic issue0, issue1, issue_rd, hold_lim;

  assign gnt0     = (state_q == ST_OWN0);
  assign gnt1     = (state_q == ST_OWN1);
  assign issue0   = req0 && gnt0;
  assign issue1   = req1 && gnt1;
  assign issue_rd = (issue0 && !we0) || (issue1 && !we1);
  assign hold_lim = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX);

  // Grant FSM: release to the waiting side with no bubble, preempt an unlocked
  // owner once it has held the port MAX_HOLD cycles while the other side waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)
          state_d = (RR_MODE != 0 && !last_owner_q) ? ST_OWN1 : ST_OWN0;
        else if (req0)
          state_d = ST_OWN0;
        else if (req1)
          state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0 && !lock0)
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        else if (hold_lim && req1 && !lock0)
          state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req1 && !lock1)
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        else if (hold_lim && req0 && !lock1)
          state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold counter counts granted cycles including the current one; last_owner
  // records every entry into an owner state for round-robin tie-breaks.
  always_comb begin
    hold_d       = hold_q;
    last_owner_d = last_owner_q;
    if (state_d != state_q) begin
      hold_d = (state_d == ST_IDLE) ? '0 : HOLD_W'(1);
      if (state_d == ST_OWN0) last_owner_d = 1'b0;
      if (state_d == ST_OWN1) last_owner_d = 1'b1;
    end else if (state_q != ST_IDLE && hold_q < HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Read-tag shift register: a read issued now surfaces READ_LAT cycles later.
  always_comb begin
    rd_vld_d    = '0;
    rd_id_d     = '0;
    rd_vld_d[0] = issue_rd;
    rd_id_d[0]  = issue1;
    for (int i = 1; i < READ_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
  end

  // Port A mux: only an issued access drives the memory; idle cycles are zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (issue0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (issue1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
  end

  assign rvalid0 = rd_vld_q[READ_LAT-1] && !rd_id_q[READ_LAT-1];
  assign rvalid1 = rd_vld_q[READ_LAT-1] &&  rd_id_q[READ_LAT-1];
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;

  // State registers; reset drops grants and discards in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      last_owner_q <= 1'b1;
      rd_vld_q     <= '0;
      rd_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_owner_q <= last_owner_d;
      rd_vld_q     <= rd_vld_d;
      rd_id_q      <= rd_id_d;
    end
  end

endmodule
